// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: synchroniser, level-tracking FSM, stretched pulses, sticky flags, irq.
// Latency: pulse_o/event_o one cycle after the synchronised level changes; irq_o one cycle later.
module multi_edge_detector #(
   parameter int CHANNELS     = 8,
   parameter int SYNC_STAGES  = 2,
   parameter int PULSE_CYCLES = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [CHANNELS-1:0]   signal_i,
   input  logic [2*CHANNELS-1:0] mode_i,
   input  logic [CHANNELS-1:0]   clear_i,
   output logic [CHANNELS-1:0]   level_o,
   output logic [CHANNELS-1:0]   pulse_o,
   output logic [CHANNELS-1:0]   event_o,
   output logic                  irq_o
);

   localparam int PW = $clog2(PULSE_CYCLES + 1);
   localparam int WW = (SYNC_STAGES > 0) ? $clog2(SYNC_STAGES + 1) : 1;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } state_t;

   logic [CHANNELS-1:0] sync;
   logic [WW-1:0]       warm_cnt;
   logic                warm_done;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign sync = signal_i;
      end else begin : g_sync
         logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            end else begin
               sync_q[0] <= signal_i;
               for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         end

         assign sync = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // FSMs stay in INIT until the synchroniser has flushed its reset zeros.
   assign warm_done = (warm_cnt == WW'(SYNC_STAGES));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         warm_cnt <= '0;
      end else if (!warm_done) begin
         warm_cnt <= warm_cnt + WW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         level_o <= '0;
         irq_o   <= 1'b0;
      end else begin
         level_o <= sync;
         irq_o   <= |event_o;
      end
   end

   generate
      for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
         state_t        state;
         logic [PW-1:0] stretch_cnt;
         logic          event_q;
         logic          rise;
         logic          fall;
         logic          qual;

         always_comb begin
            rise = (state == ST_LOW)  &&  sync[c];
            fall = (state == ST_HIGH) && !sync[c];
            qual = (rise && mode_i[2*c]) || (fall && mode_i[2*c+1]);
         end

         // Level tracking runs in every mode so a mode change cannot create an edge.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               state <= ST_INIT;
            end else begin
               case (state)
                  ST_INIT: if (warm_done) state <= sync[c] ? ST_HIGH : ST_LOW;
                  ST_LOW:  if (sync[c])   state <= ST_HIGH;
                  ST_HIGH: if (!sync[c])  state <= ST_LOW;
                  default:                state <= ST_INIT;
               endcase
            end
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               stretch_cnt <= '0;
            end else if (qual) begin
               stretch_cnt <= PW'(PULSE_CYCLES);
            end else if (stretch_cnt != '0) begin
               stretch_cnt <= stretch_cnt - PW'(1);
            end
         end

         // A new edge outranks a simultaneous clear so no event is lost.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               event_q <= 1'b0;
            end else begin
               event_q <= qual | (event_q & ~clear_i[c]);
            end
         end

         assign pulse_o[c] = (stretch_cnt != '0);
         assign event_o[c] = event_q;
      end
   endgenerate

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: one single-cycle-pulse instance and one stretched-pulse instance.
module tb_multi_edge_detector;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sig;
   logic [7:0] mode;
   logic [3:0] clr;
   logic [3:0] lvl_a, pls_a, evt_a;
   logic [3:0] lvl_b, pls_b, evt_b;
   logic       irq_a, irq_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   multi_edge_detector #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_CYCLES(1)) dut_a (
      .clk_i(clk), .rst_i(rst), .signal_i(sig), .mode_i(mode), .clear_i(clr),
      .level_o(lvl_a), .pulse_o(pls_a), .event_o(evt_a), .irq_o(irq_a)
   );

   multi_edge_detector #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_CYCLES(4)) dut_b (
      .clk_i(clk), .rst_i(rst), .signal_i(sig), .mode_i(mode), .clear_i(clr),
      .level_o(lvl_b), .pulse_o(pls_b), .event_o(evt_b), .irq_o(irq_b)
   );

   typedef struct {
      logic       rst;
      logic [3:0] sig;
      logic [7:0] mode;
      logic [3:0] clr;
      logic [3:0] lvl;
      logic [3:0] pls;
      logic [3:0] evt;
      logic       irq;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [3:0] s, input logic [7:0] m, input logic [3:0] c,
                      input logic [3:0] l, input logic [3:0] p, input logic [3:0] e, input logic i);
      vec_t v;
      v.rst = r; v.sig = s; v.mode = m; v.clr = c;
      v.lvl = l; v.pls = p; v.evt = e; v.irq = i;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; sig = 4'b0101; mode = 8'hFF; clr = 4'b0000;

      // Levels held through reset release: no edges, level visible from 3rd posedge.
      add(1, 4'b0101, 8'hFF, 4'h0, 4'b0000, 4'b0000, 4'b0000, 0);
      add(1, 4'b0101, 8'hFF, 4'h0, 4'b0000, 4'b0000, 4'b0000, 0);
      add(0, 4'b0101, 8'hFF, 4'h0, 4'b0000, 4'b0000, 4'b0000, 0);
      add(0, 4'b0101, 8'hFF, 4'h0, 4'b0000, 4'b0000, 4'b0000, 0);
      for (int k = 0; k < 8; k++)
         add(0, 4'b0101, 8'hFF, 4'h0, 4'b0101, 4'b0000, 4'b0000, 0);
      // ch0 rise-only: fall ignored, rise pulses once, event then irq.
      add(0, 4'b0100, 8'hFD, 4'h0, 4'b0101, 4'b0000, 4'b0000, 0);
      add(0, 4'b0100, 8'hFD, 4'h0, 4'b0101, 4'b0000, 4'b0000, 0);
      add(0, 4'b0100, 8'hFD, 4'h0, 4'b0100, 4'b0000, 4'b0000, 0);
      add(0, 4'b0101, 8'hFD, 4'h0, 4'b0100, 4'b0000, 4'b0000, 0);
      add(0, 4'b0101, 8'hFD, 4'h0, 4'b0100, 4'b0000, 4'b0000, 0);
      add(0, 4'b0101, 8'hFD, 4'h0, 4'b0101, 4'b0001, 4'b0001, 0);
      add(0, 4'b0101, 8'hFD, 4'h0, 4'b0101, 4'b0000, 4'b0001, 1);
      add(0, 4'b0101, 8'hFD, 4'h0, 4'b0101, 4'b0000, 4'b0001, 1);
      add(0, 4'b0100, 8'hFD, 4'h0, 4'b0101, 4'b0000, 4'b0001, 1);
      add(0, 4'b0100, 8'hFD, 4'h0, 4'b0101, 4'b0000, 4'b0001, 1);
      add(0, 4'b0100, 8'hFD, 4'h0, 4'b0100, 4'b0000, 4'b0001, 1);
      add(0, 4'b0100, 8'hFD, 4'h0, 4'b0100, 4'b0000, 4'b0001, 1);
      // Clear coinciding with a new edge keeps the flag; a later clear drops it.
      add(0, 4'b0101, 8'hFD, 4'h0, 4'b0100, 4'b0000, 4'b0001, 1);
      add(0, 4'b0101, 8'hFD, 4'h0, 4'b0100, 4'b0000, 4'b0001, 1);
      add(0, 4'b0101, 8'hFD, 4'h1, 4'b0101, 4'b0001, 4'b0001, 1);
      add(0, 4'b0101, 8'hFD, 4'h1, 4'b0101, 4'b0000, 4'b0000, 1);
      add(0, 4'b0101, 8'hFD, 4'h0, 4'b0101, 4'b0000, 4'b0000, 0);
      // ch2 off -> fall-only while high: silent switch, one pulse on the fall.
      add(0, 4'b0101, 8'hCD, 4'h0, 4'b0101, 4'b0000, 4'b0000, 0);
      add(0, 4'b0101, 8'hED, 4'h0, 4'b0101, 4'b0000, 4'b0000, 0);
      add(0, 4'b0101, 8'hED, 4'h0, 4'b0101, 4'b0000, 4'b0000, 0);
      add(0, 4'b0001, 8'hED, 4'h0, 4'b0101, 4'b0000, 4'b0000, 0);
      add(0, 4'b0001, 8'hED, 4'h0, 4'b0101, 4'b0000, 4'b0000, 0);
      add(0, 4'b0001, 8'hED, 4'h0, 4'b0001, 4'b0100, 4'b0100, 0);
      add(0, 4'b0001, 8'hED, 4'h0, 4'b0001, 4'b0000, 4'b0100, 1);
      // All four channels change at once in both-edge mode.
      add(0, 4'b1110, 8'hFF, 4'h0, 4'b0001, 4'b0000, 4'b0100, 1);
      add(0, 4'b1110, 8'hFF, 4'h0, 4'b0001, 4'b0000, 4'b0100, 1);
      add(0, 4'b1110, 8'hFF, 4'h0, 4'b1110, 4'b1111, 4'b1111, 1);
      add(0, 4'b1110, 8'hFF, 4'hF, 4'b1110, 4'b0000, 4'b0000, 1);
      add(0, 4'b1110, 8'hFF, 4'h0, 4'b1110, 4'b0000, 4'b0000, 0);
      add(1, 4'b1110, 8'hFF, 4'h0, 4'b0000, 4'b0000, 4'b0000, 0);

      foreach (tbl[i]) begin
         rst = tbl[i].rst; sig = tbl[i].sig; mode = tbl[i].mode; clr = tbl[i].clr;
         step();
         check($sformatf("row%0d lvl/pls/evt/irq", i),
               {3'b000, lvl_a, pls_a, evt_a, irq_a},
               {3'b000, tbl[i].lvl, tbl[i].pls, tbl[i].evt, tbl[i].irq});
      end

      // Retrigger on the stretched instance: edges sampled at N and N+2.
      rst = 1'b1; sig = 4'b0000; mode = 8'hFF; clr = 4'h0;
      repeat (2) step();
      rst = 1'b0;
      repeat (10) step();
      sig = 4'b0010;
      for (int k = 0; k <= 10; k++) begin
         if (k == 2) sig = 4'b0000;
         step();
         check($sformatf("retrig pls_b[1] k=%0d", k), {15'd0, pls_b[1]}, {15'd0, (k >= 2 && k <= 7)});
         check($sformatf("single pls_a[1] k=%0d", k), {15'd0, pls_a[1]}, {15'd0, (k == 2 || k == 4)});
      end
      check("retrig evt_b", {12'd0, evt_b}, 16'h0002);

      // Reset in the middle of a stretched pulse.
      sig = 4'b1000;
      repeat (3) step();
      check("pulse before reset", {12'd0, pls_b}, 16'h0008);
      rst = 1'b1;
      step();
      check("reset mid-pulse b", {3'b000, lvl_b, pls_b, evt_b, irq_b}, 16'h0000);
      check("reset mid-pulse a", {3'b000, lvl_a, pls_a, evt_a, irq_a}, 16'h0000);

      // Reset in the middle of warm-up with levels held high.
      rst = 1'b0; sig = 4'b1111;
      step();
      rst = 1'b1;
      step();
      check("reset mid-warmup", {3'b000, lvl_b, pls_b, evt_b, irq_b}, 16'h0000);
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         check($sformatf("warmup k=%0d", k),
               {lvl_a, pls_a, pls_b, evt_a | evt_b},
               {(k >= 3) ? 4'b1111 : 4'b0000, 4'b0000, 4'b0000, 4'b0000});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
